// File: rtl/ahb_pkg.sv
// Shared AHB definitions: HTRANS encodings and the arbiter state enumeration.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN  = 2'd1,
        ARB_LOCK = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbitration bus bundle: masters drive requests/transfer info, the arbiter drives grants.
interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 4
) ();
    localparam int IW = $clog2(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic                   hready;
    logic [1:0]             htrans;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [IW-1:0]          hmaster;
    logic                   hmastlock;

    modport master (
        output hbusreq, hlock, hready, htrans,
        input  hgrant, hmaster, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, hready, htrans,
        output hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_arb_pick.sv
// Combinational winner search: first unmasked requester found walking upward from start_i (wrapping).
module ahb_arb_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int IW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IW-1:0]          start_i,
    input  logic [NUM_MASTERS-1:0] excl_i,
    output logic [NUM_MASTERS-1:0] win_o,
    output logic [IW-1:0]          win_idx_o,
    output logic                   valid_o
);
    logic [NUM_MASTERS-1:0] req_m_s;

    assign req_m_s = req_i & ~excl_i;

    // Rotating search; the first hit locks out later candidates
    always_comb begin
        int unsigned idx;
        logic        found;
        found     = 1'b0;
        idx       = 0;
        win_o     = '0;
        win_idx_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = (int'(start_i) + i) % NUM_MASTERS;
            if (!found && req_m_s[idx]) begin
                found      = 1'b1;
                win_o[idx] = 1'b1;
                win_idx_o  = IW'(idx);
            end else begin
                found = found;
            end
        end
        valid_o = found;
    end
endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter with burst-length limit and locked sequences.
// Define AHB_ARB_RR_EN for round-robin search order; default build is fixed priority.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_BEATS   = 8,
    parameter int DEF_MASTER  = 0
) (
    input  logic          hclk,
    input  logic          hresetn,
    ahb_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam logic [1:0] S_IDLE = ARB_IDLE;
    localparam logic [1:0] S_OWN  = ARB_OWN;
    localparam logic [1:0] S_LOCK = ARB_LOCK;
    localparam logic [NUM_MASTERS-1:0] DEF_GNT = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEF_MASTER;
    localparam logic [IW-1:0] DEF_IDX  = IW'(DEF_MASTER);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);

    logic [1:0]             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [IW-1:0]          hmaster_q, hmaster_d;
    logic                   lock_q, lock_d;
    logic [BW-1:0]          beat_q, beat_d;

    logic [IW-1:0]          start_s;
    logic [NUM_MASTERS-1:0] excl_s, win_s;
    logic [IW-1:0]          win_idx_s;
    logic                   win_vld_s, limit_s, rearb_s, take_s;

    // Beat limit only forces a handover when somebody else is waiting
    assign limit_s = (beat_q == LAST_BEAT) && (|(bus.hbusreq & ~gnt_q));
    assign excl_s  = (state_q == S_OWN && limit_s && bus.hbusreq[owner_q]) ? gnt_q : '0;

    ahb_arb_pick #(.NUM_MASTERS(NUM_MASTERS), .IW(IW)) u_pick (
        .req_i     (bus.hbusreq),
        .start_i   (start_s),
        .excl_i    (excl_s),
        .win_o     (win_s),
        .win_idx_o (win_idx_s),
        .valid_o   (win_vld_s)
    );

    // Next-state logic; everything holds while hready is low
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        hmaster_d = hmaster_q;
        lock_d    = lock_q;
        beat_d    = beat_q;
        rearb_s   = 1'b0;
        take_s    = 1'b0;
        if (bus.hready) begin
            hmaster_d = owner_q;
            case (state_q)
                S_IDLE: rearb_s = 1'b1;
                S_OWN: begin
                    if (bus.hlock[owner_q]) begin
                        state_d = S_LOCK;
                        lock_d  = 1'b1;
                    end else if (!bus.hbusreq[owner_q] || limit_s) begin
                        rearb_s = 1'b1;
                    end else if (bus.htrans[1] && beat_q != LAST_BEAT) begin
                        beat_d = beat_q + BW'(1);
                    end else begin
                        beat_d = beat_q;
                    end
                end
                S_LOCK: begin
                    if (bus.hlock[owner_q]) begin
                        lock_d = 1'b1;
                    end else if (!bus.hbusreq[owner_q]) begin
                        rearb_s = 1'b1;
                    end else begin
                        state_d = S_OWN;
                        lock_d  = 1'b0;
                    end
                end
                default: rearb_s = 1'b1;
            endcase
            if (rearb_s) begin
                beat_d = '0;
                if (win_vld_s) begin
                    take_s  = 1'b1;
                    gnt_d   = win_s;
                    owner_d = win_idx_s;
                    lock_d  = bus.hlock[win_idx_s];
                    state_d = bus.hlock[win_idx_s] ? S_LOCK : S_OWN;
                end else begin
                    gnt_d   = DEF_GNT;
                    owner_d = DEF_IDX;
                    lock_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end else begin
                take_s = 1'b0;
            end
        end else begin
            hmaster_d = hmaster_q;
        end
    end

    // Arbiter state registers
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q   <= S_IDLE;
            gnt_q     <= DEF_GNT;
            owner_q   <= DEF_IDX;
            hmaster_q <= DEF_IDX;
            lock_q    <= 1'b0;
            beat_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            hmaster_q <= hmaster_d;
            lock_q    <= lock_d;
            beat_q    <= beat_d;
        end
    end

`ifdef AHB_ARB_RR_EN
    logic [IW-1:0] rr_q;

    // Search for the next grant starts just after the last winner
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            rr_q <= '0;
        end else if (take_s) begin
            rr_q <= (win_idx_s == IW'(NUM_MASTERS - 1)) ? '0 : win_idx_s + IW'(1);
        end else begin
            rr_q <= rr_q;
        end
    end

    assign start_s = rr_q;
`else
    logic unused_take_s;

    assign unused_take_s = take_s;
    assign start_s       = '0;
`endif

    assign bus.hgrant    = gnt_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = lock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed-vector bench for ahb_arbiter (NUM_MASTERS=4, MAX_BEATS=8, DEF_MASTER=0).
module tb_ahb_arbiter;
    import ahb_pkg::*;

    logic hclk = 1'b0;
    logic hresetn;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] seq [5];

    ahb_arbiter_if #(.NUM_MASTERS(4)) bus ();

    ahb_arbiter #(.NUM_MASTERS(4), .MAX_BEATS(8), .DEF_MASTER(0)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    always #5 hclk = ~hclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] m, input logic l);
        check_eq({tag, ".hgrant"}, 32'(bus.hgrant), 32'(g));
        check_eq({tag, ".hmaster"}, 32'(bus.hmaster), 32'(m));
        check_eq({tag, ".hmastlock"}, 32'(bus.hmastlock), 32'(l));
    endtask

    initial begin
        hresetn     = 1'b0;
        bus.hbusreq = 4'b0000;
        bus.hlock   = 4'b0000;
        bus.hready  = 1'b1;
        bus.htrans  = HTRANS_IDLE;
        step();
        step();
        expect_out("reset", 4'b0001, 2'd0, 1'b0);
        hresetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step();
            expect_out($sformatf("park%0d", i), 4'b0001, 2'd0, 1'b0);
        end

        // Fixed priority winner, address phase one edge later, release with waiting master
        bus.hbusreq = 4'b0110;
        step(); expect_out("grant1", 4'b0010, 2'd0, 1'b0);
        step(); expect_out("addr1", 4'b0010, 2'd1, 1'b0);
        bus.hbusreq = 4'b0100;
        step(); expect_out("handover2", 4'b0100, 2'd1, 1'b0);
        step(); expect_out("addr2", 4'b0100, 2'd2, 1'b0);

        // Beat limit: master 1 bursts 8 beats while master 3 waits
        bus.hbusreq = 4'b0000;
        step(); expect_out("to_idle", 4'b0001, 2'd2, 1'b0);
        bus.hbusreq = 4'b0010;
        step(); expect_out("grant1b", 4'b0010, 2'd0, 1'b0);
        bus.hbusreq = 4'b1010;
        for (int b = 1; b <= 8; b++) begin
            bus.htrans = (b == 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
            step();
            check_eq($sformatf("beat%0d.hgrant", b), 32'(bus.hgrant), (b == 8) ? 32'h8 : 32'h2);
        end
        check_eq("beat8.hmaster", 32'(bus.hmaster), 32'd1);
        bus.htrans = HTRANS_IDLE;
        step(); expect_out("limit_addr3", 4'b1000, 2'd3, 1'b0);

        // Locked sequence outlasts the beat limit
        bus.hbusreq = 4'b0000;
        step(); expect_out("to_idle2", 4'b0001, 2'd3, 1'b0);
        bus.hbusreq = 4'b0100;
        step(); expect_out("grant2", 4'b0100, 2'd0, 1'b0);
        bus.hbusreq = 4'b0101;
        bus.hlock   = 4'b0100;
        bus.htrans  = HTRANS_SEQ;
        step(); expect_out("lock_enter", 4'b0100, 2'd2, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step();
            check_eq($sformatf("lock%0d.hgrant", i), 32'(bus.hgrant), 32'h4);
            check_eq($sformatf("lock%0d.hmastlock", i), 32'(bus.hmastlock), 32'd1);
        end
        bus.hlock   = 4'b0000;
        bus.hbusreq = 4'b0001;
        bus.htrans  = HTRANS_IDLE;
        step(); expect_out("lock_exit", 4'b0001, 2'd2, 1'b0);

        // Handover requested while the slave stalls
        bus.hready  = 1'b0;
        bus.hbusreq = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out($sformatf("stall%0d", i), 4'b0001, 2'd2, 1'b0);
        end
        bus.hready = 1'b1;
        step(); expect_out("stall_release", 4'b0010, 2'd0, 1'b0);
        step(); expect_out("stall_addr", 4'b0010, 2'd1, 1'b0);

        // Reset in the middle of a locked sequence
        bus.hlock = 4'b0010;
        step(); expect_out("lock1", 4'b0010, 2'd1, 1'b1);
        hresetn = 1'b0;
        step(); expect_out("rst_in_lock", 4'b0001, 2'd0, 1'b0);
        hresetn     = 1'b1;
        bus.hlock   = 4'b0000;
        bus.hbusreq = 4'b0000;
        step(); expect_out("post_rst", 4'b0001, 2'd0, 1'b0);

        // All masters request; each owner releases after one beat
`ifdef AHB_ARB_RR_EN
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
`else
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0001; seq[3] = 4'b0010; seq[4] = 4'b0001;
`endif
        bus.hbusreq = 4'b1111;
        step();
        check_eq("rot0.hgrant", 32'(bus.hgrant), 32'(seq[0]));
        for (int k = 1; k < 5; k++) begin
            bus.htrans = HTRANS_NONSEQ;
            step();
            check_eq($sformatf("rot%0d.beat", k), 32'(bus.hgrant), 32'(seq[k-1]));
            bus.hbusreq = 4'b1111 & ~seq[k-1];
            bus.htrans  = HTRANS_IDLE;
            step();
            check_eq($sformatf("rot%0d.hgrant", k), 32'(bus.hgrant), 32'(seq[k]));
            bus.hbusreq = 4'b1111;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
